config_cell_mc: RTL and testbench

//  Multi-context successor to the single-register CGRA config cell. Config bits shift serially along
//  the daisy chain into a staging register; a commit strobe copies a fully loaded word into one of
//  NUM_CTX context slots. A context select drives the PE/mux select bus, so the fabric can switch

---
 rtl/config_cell_mc_pkg.sv | 23 ++
 rtl/config_cell_mc_ctx_bank.sv | 55 +++++
 rtl/config_cell_mc.sv | 153 +++++++++++++++
 tb/tb_config_cell_mc.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/config_cell_mc_pkg.sv
// config_cell_mc_pkg
//   Shared definitions for the multi-context config cell:
//     clog2_min1       - index width for a count of items, never below 1 bit
//     cnt_width        - width needed to hold the values 0..len
//     commit_result_e  - outcome of a commit attempt, as decided by the top level
package config_cell_mc_pkg;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

  typedef enum logic [1:0] {
    CMT_OK       = 2'd0,
    CMT_NOT_FULL = 2'd1,
    CMT_BAD_CTX  = 2'd2,
    CMT_PARITY   = 2'd3
  } commit_result_e;

endpackage

// File: rtl/config_cell_mc_ctx_bank.sv
// config_cell_mc_ctx_bank
//   NUM_CTX x SIZE array of stored config contexts.
//   A single write port loads one slot.
//   A registered read port drives rd_data from slot[rd_ctx] every cycle.
//   If rd_ctx is out of range, rd_data holds its previous value.
//   Ports:
//     Config_Clock, Config_Reset  clock / async active-high reset (clears all slots and rd_data)
//     wr_en, wr_ctx, wr_data      write strobe, destination slot, word to store
//     rd_ctx                      slot driving rd_data
//     rd_data                     registered active context word
module config_cell_mc_ctx_bank #(
  parameter int SIZE    = 1,
  parameter int NUM_CTX = 2,
  parameter int CTX_W   = 1
) (
  input  logic             Config_Clock,
  input  logic             Config_Reset,
  input  logic             wr_en,
  input  logic [CTX_W-1:0] wr_ctx,
  input  logic [SIZE-1:0]  wr_data,
  input  logic [CTX_W-1:0] rd_ctx,
  output logic [SIZE-1:0]  rd_data
);

  localparam logic [CTX_W:0] NUM_CTX_EXT = (CTX_W+1)'(NUM_CTX);

  logic [SIZE-1:0] slots [NUM_CTX];

  logic wr_in_range;
  logic rd_in_range;

  assign wr_in_range = ({1'b0, wr_ctx} < NUM_CTX_EXT);
  assign rd_in_range = ({1'b0, rd_ctx} < NUM_CTX_EXT);

  always_ff @(posedge Config_Clock or posedge Config_Reset) begin
    if (Config_Reset) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        slots[i] <= '0;
      end
    end else if (wr_en && wr_in_range) begin
      slots[wr_ctx] <= wr_data;
    end
  end

  // The read samples the slot value from before this edge.
  // A commit into the selected slot therefore reaches rd_data one cycle later.
  always_ff @(posedge Config_Clock or posedge Config_Reset) begin
    if (Config_Reset) begin
      rd_data <= '0;
    end else if (rd_in_range) begin
      rd_data <= slots[rd_ctx];
    end
  end

endmodule

// File: rtl/config_cell_mc.sv
// config_cell_mc
//   Multi-context CGRA config cell.
//   Config bits shift serially, LSB first, through a staging register on the daisy chain.
//   A commit strobe copies a fully loaded staging word into one of NUM_CTX context slots.
//   CtxSel picks which slot drives the select bus, so the fabric can switch contexts while
//   the next context is being shifted in.
//   Optional feature: define CONFIG_CELL_PARITY_EN to append one even-parity bit to the chain.
//   A commit is then rejected (parity_err) when the parity bit does not match the word.
//   Ports:
//     Config_Clock, Config_Reset  clock / asynchronous active-high reset
//     ConfigIn, ConfigEnable      serial chain input and shift enable
//     ConfigCommit, ConfigCtxWr   one-cycle commit strobe and destination slot
//     CtxSel                      active context driving select
//     ConfigOut                   registered serial output to the next cell
//     select                      registered active context word
//     shift_full                  staging holds a complete word since the last commit
//     commit_err, parity_err      sticky error flags, cleared only by reset
module config_cell_mc
  import config_cell_mc_pkg::*;
#(
  parameter int SIZE    = 1,
  parameter int NUM_CTX = 2,
  parameter int CTX_W   = clog2_min1(NUM_CTX)
) (
  input  logic             Config_Clock,
  input  logic             Config_Reset,
  input  logic             ConfigIn,
  input  logic             ConfigEnable,
  input  logic             ConfigCommit,
  input  logic [CTX_W-1:0] ConfigCtxWr,
  input  logic [CTX_W-1:0] CtxSel,
  output logic             ConfigOut,
  output logic [SIZE-1:0]  select,
  output logic             shift_full,
  output logic             commit_err,
  output logic             parity_err
);

`ifdef CONFIG_CELL_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  localparam int                CHAIN_L     = SIZE + PAR_BITS;
  localparam int                CNT_W       = cnt_width(CHAIN_L);
  localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(CHAIN_L);
  localparam logic [CTX_W:0]    NUM_CTX_EXT = (CTX_W+1)'(NUM_CTX);

  logic [CHAIN_L-1:0] stg;
  logic [CHAIN_L-1:0] stg_next;
  logic [CNT_W-1:0]   bit_cnt;
  logic               parity_ok;
  commit_result_e     cmt_res;
  logic               cmt_accept;
  logic               commit_err_q;

  // New bits enter at the top of the staging register and leave from bit 0.
  generate
    if (CHAIN_L == 1) begin : g_chain_one
      assign stg_next = ConfigIn;
    end else begin : g_chain_multi
      assign stg_next = {ConfigIn, stg[CHAIN_L-1:1]};
    end
  endgenerate

`ifdef CONFIG_CELL_PARITY_EN
  // stg[SIZE] is the last bit shifted in. It makes the XOR over stg[SIZE:0] even.
  assign parity_ok = ~(^stg);
`else
  assign parity_ok = 1'b1;
`endif

  assign shift_full = (bit_cnt == CNT_FULL);

  always_comb begin
    cmt_res = CMT_OK;
    if (!shift_full) begin
      cmt_res = CMT_NOT_FULL;
    end else if ({1'b0, ConfigCtxWr} >= NUM_CTX_EXT) begin
      cmt_res = CMT_BAD_CTX;
    end else if (!parity_ok) begin
      cmt_res = CMT_PARITY;
    end
  end

  assign cmt_accept = ConfigCommit && (cmt_res == CMT_OK);

  // Staging, chain output and bit counter.
  // A rejected commit leaves the counter alone.
  // Shifts that coincide with a rejected commit are still counted, so the count keeps
  // tracking the staging contents.
  always_ff @(posedge Config_Clock or posedge Config_Reset) begin
    if (Config_Reset) begin
      stg       <= '0;
      ConfigOut <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      if (ConfigEnable) begin
        stg       <= stg_next;
        ConfigOut <= stg[0];
      end
      if (cmt_accept) begin
        // The bit shifted in on the commit cycle belongs to the next word.
        bit_cnt <= ConfigEnable ? CNT_W'(1) : '0;
      end else if (ConfigEnable && !shift_full) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Config_Clock or posedge Config_Reset) begin
    if (Config_Reset) begin
      commit_err_q <= 1'b0;
    end else if (ConfigCommit && (cmt_res == CMT_NOT_FULL || cmt_res == CMT_BAD_CTX)) begin
      commit_err_q <= 1'b1;
    end
  end

  assign commit_err = commit_err_q;

`ifdef CONFIG_CELL_PARITY_EN
  logic parity_err_q;

  always_ff @(posedge Config_Clock or posedge Config_Reset) begin
    if (Config_Reset) begin
      parity_err_q <= 1'b0;
    end else if (ConfigCommit && cmt_res == CMT_PARITY) begin
      parity_err_q <= 1'b1;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  // The slot receives the staging word as it stood before any coincident shift.
  config_cell_mc_ctx_bank #(
    .SIZE    (SIZE),
    .NUM_CTX (NUM_CTX),
    .CTX_W   (CTX_W)
  ) u_bank (
    .Config_Clock (Config_Clock),
    .Config_Reset (Config_Reset),
    .wr_en        (cmt_accept),
    .wr_ctx       (ConfigCtxWr),
    .wr_data      (stg[SIZE-1:0]),
    .rd_ctx       (CtxSel),
    .rd_data      (select)
  );

endmodule

// File: tb/tb_config_cell_mc.sv
// tb_config_cell_mc
//   Directed bench for config_cell_mc with SIZE=8 and NUM_CTX=3 (CTX_W=2).
//   The bench follows the DUT build: with CONFIG_CELL_PARITY_EN defined, every word is
//   followed by its parity bit on the chain.
//   Handshake: inputs change 1 ns after a rising edge and are sampled at the next edge.
//   Outputs are checked 1 ns after the edge that updates them.
module tb_config_cell_mc;

  localparam int SIZE    = 8;
  localparam int NUM_CTX = 3;
  localparam int CTX_W   = 2;
`ifdef CONFIG_CELL_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int L = SIZE + PAR;

  logic             Config_Clock;
  logic             Config_Reset;
  logic             ConfigIn;
  logic             ConfigEnable;
  logic             ConfigCommit;
  logic [CTX_W-1:0] ConfigCtxWr;
  logic [CTX_W-1:0] CtxSel;
  logic             ConfigOut;
  logic [SIZE-1:0]  select;
  logic             shift_full;
  logic             commit_err;
  logic             parity_err;

  int checks = 0;
  int errors = 0;

  config_cell_mc #(
    .SIZE    (SIZE),
    .NUM_CTX (NUM_CTX)
  ) dut (
    .Config_Clock (Config_Clock),
    .Config_Reset (Config_Reset),
    .ConfigIn     (ConfigIn),
    .ConfigEnable (ConfigEnable),
    .ConfigCommit (ConfigCommit),
    .ConfigCtxWr  (ConfigCtxWr),
    .CtxSel       (CtxSel),
    .ConfigOut    (ConfigOut),
    .select       (select),
    .shift_full   (shift_full),
    .commit_err   (commit_err),
    .parity_err   (parity_err)
  );

  // Clock / reset block
  initial begin
    Config_Clock = 1'b0;
    forever #5 Config_Clock = ~Config_Clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge Config_Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic shift_bits(input logic [31:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      ConfigEnable = 1'b1;
      ConfigIn     = data[i];
      tick();
    end
    ConfigEnable = 1'b0;
    ConfigIn     = 1'b0;
  endtask

  // Shift a full word LSB first, followed by parity bit p in the parity build.
  task automatic shift_word(input logic [7:0] w, input logic p);
    shift_bits({24'h0, w}, SIZE);
    if (PAR == 1) shift_bits({31'h0, p}, 1);
  endtask

  task automatic commit(input logic [CTX_W-1:0] ctx);
    ConfigCommit = 1'b1;
    ConfigCtxWr  = ctx;
    tick();
    ConfigCommit = 1'b0;
  endtask

  initial begin
    Config_Reset = 1'b1;
    ConfigIn     = 1'b0;
    ConfigEnable = 1'b0;
    ConfigCommit = 1'b0;
    ConfigCtxWr  = '0;
    CtxSel       = '0;
    tick();
    tick();
    Config_Reset = 1'b0;
    tick();

    // Reset state
    chk("rst_select",     32'(select),     32'h0);
    chk("rst_configout",  32'(ConfigOut),  32'h0);
    chk("rst_shift_full", 32'(shift_full), 32'h0);
    chk("rst_commit_err", 32'(commit_err), 32'h0);
    chk("rst_parity_err", 32'(parity_err), 32'h0);

    // 1: load A5, commit ctx1, select follows one cycle later
    shift_word(8'hA5, 1'b0);
    chk("t1_full", 32'(shift_full), 32'h1);
    CtxSel = 2'd1;
    commit(2'd1);
    chk("t1_full_clr", 32'(shift_full), 32'h0);
    chk("t1_sel_lat",  32'(select),     32'h0);
    tick();
    chk("t1_select",   32'(select),     32'hA5);
    chk("t1_cerr",     32'(commit_err), 32'h0);

    // 2: chain delay of L enabled cycles, with a disabled gap
    shift_bits(32'h0, L + 1);
    chk("t2_flush_out", 32'(ConfigOut),  32'h0);
    chk("t2_sat_full",  32'(shift_full), 32'h1);
    ConfigEnable = 1'b1;
    ConfigIn     = 1'b1;
    tick();
    chk("t2_out_k1", 32'(ConfigOut), 32'h0);
    ConfigIn = 1'b0;
    for (int k = 2; k <= L + 2; k++) begin
      if (k == 4) begin
        ConfigEnable = 1'b0;
        tick();
        tick();
        chk("t2_gap_hold", 32'(ConfigOut), 32'h0);
        ConfigEnable = 1'b1;
      end
      tick();
      chk($sformatf("t2_out_k%0d", k), 32'(ConfigOut), 32'(k == L + 1));
    end
    ConfigEnable = 1'b0;

    // 3: early commit rejected, then completed word accepted
    commit(2'd2);
    chk("t3_zero_cnt", 32'(shift_full), 32'h0);
    chk("t3_ok_cerr",  32'(commit_err), 32'h0);
    shift_bits(32'h3C, 5);
    CtxSel = 2'd0;
    commit(2'd0);
    chk("t3_early_cerr", 32'(commit_err), 32'h1);
    chk("t3_early_full", 32'(shift_full), 32'h0);
    tick();
    chk("t3_slot_kept",  32'(select),     32'h0);
    shift_bits(32'h3C >> 5, 3);
    if (PAR == 1) shift_bits(32'h0, 1);
    chk("t3_full", 32'(shift_full), 32'h1);
    commit(2'd0);
    tick();
    chk("t3_select", 32'(select), 32'h3C);

    // Reset mid-shift: outputs clear within the same cycle
    ConfigEnable = 1'b1;
    ConfigIn     = 1'b1;
    tick();
    tick();
    #3;
    Config_Reset = 1'b1;
    #1;
    chk("mrst_select", 32'(select),     32'h0);
    chk("mrst_out",    32'(ConfigOut),  32'h0);
    chk("mrst_full",   32'(shift_full), 32'h0);
    chk("mrst_cerr",   32'(commit_err), 32'h0);
    chk("mrst_perr",   32'(parity_err), 32'h0);
    ConfigEnable = 1'b0;
    ConfigIn     = 1'b0;
    tick();
    Config_Reset = 1'b0;
    tick();
    chk("mrst_slot0", 32'(select), 32'h0);

    // 4: out-of-range commit and out-of-range select
    shift_word(8'h5A, 1'b0);
    commit(2'd3);
    chk("t4_cerr",      32'(commit_err), 32'h1);
    chk("t4_full_kept", 32'(shift_full), 32'h1);
    CtxSel = 2'd1;
    commit(2'd1);
    tick();
    chk("t4_sel1", 32'(select), 32'h5A);
    CtxSel = 2'd3;
    tick();
    tick();
    chk("t4_sel_hold", 32'(select), 32'h5A);
    CtxSel = 2'd0;
    tick();
    chk("t4_sel0", 32'(select), 32'h0);
    CtxSel = 2'd2;
    tick();
    chk("t4_sel2", 32'(select), 32'h0);

    // 5: shift and commit on the same cycle into selected ctx0
    shift_word(8'hC3, 1'b0);
    CtxSel       = 2'd0;
    ConfigEnable = 1'b1;
    ConfigIn     = 1'b1;
    commit(2'd0);
    ConfigEnable = 1'b0;
    ConfigIn     = 1'b0;
    chk("t5_cnt1_full", 32'(shift_full), 32'h0);
    tick();
    chk("t5_select", 32'(select), 32'hC3);
    shift_bits(32'h0, L - 2);
    chk("t5_not_yet", 32'(shift_full), 32'h0);
    shift_bits(32'h0, 1);
    chk("t5_full", 32'(shift_full), 32'h1);

    // 6: parity check on commit (default build accepts any word)
    CtxSel = 2'd2;
    if (PAR == 1) begin
      shift_word(8'h01, 1'b0);
      commit(2'd2);
      chk("t6_perr", 32'(parity_err), 32'h1);
      tick();
      chk("t6_no_write", 32'(select), 32'h0);
    end
    shift_word(8'h01, 1'b1);
    commit(2'd2);
    tick();
    chk("t6_select", 32'(select), 32'h01);
    chk("t6_perr_final", 32'(parity_err), 32'(PAR));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
